// File: rtl/modulo_abastecimento_rolhas_principal_pkg.sv
// Shared constants and state encoding for the primary cork reservoir feeder
// and the related cork-limit checkers.
package modulo_abastecimento_rolhas_principal_pkg;

    localparam int WIDTH  = 7;
    localparam int CAP    = 20;
    localparam int LIMIAR = 5;
    localparam int LOTE   = 15;

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        ESPERA = 2'b01,
        TRANSF = 2'b10,
        FIM    = 2'b11
    } estado_t;

    // Legal parameter set: threshold within capacity, non-empty batch, all counts fit the width.
    function automatic bit parametros_validos(input int width, input int cap,
                                              input int limiar, input int lote);
        return (limiar <= cap) && (lote >= 1) && (width >= 1) && (width <= 31) &&
               (cap < (1 << width)) && (lote < (1 << width));
    endfunction

endpackage

// File: rtl/modulo_contador_saturado_up_down.sv
// Up/down counter that saturates at 0 and CAP; simultaneous inc and dec hold the value.
module modulo_contador_saturado_up_down #(
    parameter int WIDTH = 7,
    parameter int CAP   = 20
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAP);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt < CAP_W) begin
                cnt <= cnt + WIDTH'(1);
            end
        end else if (dec && !inc) begin
            if (cnt != '0) begin
                cnt <= cnt - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/modulo_abastecimento_rolhas_principal.sv
// Primary cork reservoir: refills in batches from the secondary buffer when low
// and tracks capping consumption.
module modulo_abastecimento_rolhas_principal
    import modulo_abastecimento_rolhas_principal_pkg::*;
#(
    parameter int WIDTH  = modulo_abastecimento_rolhas_principal_pkg::WIDTH,
    parameter int CAP    = modulo_abastecimento_rolhas_principal_pkg::CAP,
    parameter int LIMIAR = modulo_abastecimento_rolhas_principal_pkg::LIMIAR,
    parameter int LOTE   = modulo_abastecimento_rolhas_principal_pkg::LOTE
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             consumo,
    input  logic [WIDTH-1:0] sec_disp,
    output logic             sec_dec,
    output logic [WIDTH-1:0] reg_r,
    output logic             ro,
    output logic             min_signal,
    output logic             em_transf,
    output logic [1:0]       estado,
    output logic             erro_underflow
);

    generate
        if (!parametros_validos(WIDTH, CAP, LIMIAR, LOTE)) begin : g_parametros_invalidos
            $error("modulo_abastecimento_rolhas_principal: illegal WIDTH/CAP/LIMIAR/LOTE");
        end
    endgenerate

    localparam logic [WIDTH-1:0] CAP_W    = WIDTH'(CAP);
    localparam logic [WIDTH-1:0] LIMIAR_W = WIDTH'(LIMIAR);
    localparam logic [WIDTH-1:0] LOTE_W   = WIDTH'(LOTE);

    estado_t          estado_q;
    estado_t          estado_d;
    logic [WIDTH-1:0] lote_cnt;
    logic [WIDTH-1:0] lote_d;
    logic             transferir;
    logic             sem_saldo;
    logic             fim_lote;

    // A pulse still in sec_dec has not yet been applied to sec_disp, so it counts against it.
    assign sem_saldo = (sec_disp == '0) || (sec_dec && (sec_disp == WIDTH'(1)));
    assign fim_lote  = (lote_cnt >= LOTE_W) || (reg_r >= CAP_W) || sem_saldo || !enable;

    always_ff @(posedge clk) begin
        if (clr) begin
            estado_q       <= OCIOSO;
            lote_cnt       <= '0;
            sec_dec        <= 1'b0;
            erro_underflow <= 1'b0;
        end else begin
            estado_q <= estado_d;
            lote_cnt <= lote_d;
            sec_dec  <= transferir;
            if (consumo && (reg_r == '0)) begin
                erro_underflow <= 1'b1;
            end
        end
    end

    always_comb begin
        estado_d   = estado_q;
        lote_d     = lote_cnt;
        transferir = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (enable && (reg_r < LIMIAR_W)) begin
                    estado_d = ESPERA;
                end
            end
            ESPERA: begin
                if (!enable) begin
                    estado_d = OCIOSO;
                end else if (sec_disp != '0) begin
                    estado_d = TRANSF;
                    lote_d   = '0;
                end
            end
            TRANSF: begin
                if (fim_lote) begin
                    estado_d = FIM;
                end else begin
                    transferir = 1'b1;
                    lote_d     = lote_cnt + WIDTH'(1);
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_comb begin
        ro         = (reg_r == '0);
        min_signal = (reg_r < LIMIAR_W);
        em_transf  = (estado_q == TRANSF);
        estado     = estado_q;
    end

    modulo_contador_saturado_up_down #(
        .WIDTH (WIDTH),
        .CAP   (CAP)
    ) u_contador_reg_r (
        .clk (clk),
        .clr (clr),
        .inc (transferir),
        .dec (consumo),
        .cnt (reg_r)
    );

endmodule

// File: tb/tb_modulo_abastecimento_rolhas_principal.sv
// Directed and randomized checks of the primary cork feeder against a behavioural model;
// a second instance with the threshold raised to CAP exercises the saturation limit.
module tb_modulo_abastecimento_rolhas_principal;
    import modulo_abastecimento_rolhas_principal_pkg::*;

    localparam int W = modulo_abastecimento_rolhas_principal_pkg::WIDTH;

    logic         clk;
    logic         clr;
    logic         enable;
    logic         consumo;
    logic [W-1:0] sec_disp;

    logic         sec_dec1, ro1, min1, em1, err1;
    logic [W-1:0] reg1;
    logic [1:0]   estado1;
    logic         sec_dec2, ro2, min2, em2, err2;
    logic [W-1:0] reg2;
    logic [1:0]   estado2;

    int vectors;
    int miscompares;
    int sec_buf;
    int pulses1;

    typedef struct {
        int reg_v;
        int fase;
        int lote;
        bit pulso;
        bit erro;
    } modelo_t;

    modelo_t m1;
    modelo_t m2;

    modulo_abastecimento_rolhas_principal dut (
        .clk            (clk),
        .clr            (clr),
        .enable         (enable),
        .consumo        (consumo),
        .sec_disp       (sec_disp),
        .sec_dec        (sec_dec1),
        .reg_r          (reg1),
        .ro             (ro1),
        .min_signal     (min1),
        .em_transf      (em1),
        .estado         (estado1),
        .erro_underflow (err1)
    );

    modulo_abastecimento_rolhas_principal #(
        .LIMIAR (CAP)
    ) dut_cap (
        .clk            (clk),
        .clr            (clr),
        .enable         (enable),
        .consumo        (consumo),
        .sec_disp       (sec_disp),
        .sec_dec        (sec_dec2),
        .reg_r          (reg2),
        .ro             (ro2),
        .min_signal     (min2),
        .em_transf      (em2),
        .estado         (estado2),
        .erro_underflow (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phases: 0 idle, 1 waiting for buffer, 2 transferring, 3 end of batch.
    function automatic modelo_t mstep(input modelo_t m, input int limiar, input bit en,
                                      input bit cons, input bit c, input int disp);
        modelo_t n;
        int      delta;
        bit      mover;
        if (c) begin
            n.reg_v = 0; n.fase = 0; n.lote = 0; n.pulso = 0; n.erro = 0;
            return n;
        end
        n = m;
        mover = 0;
        if (m.fase == 0) begin
            if (en && m.reg_v < limiar) n.fase = 1;
        end else if (m.fase == 1) begin
            if (!en) n.fase = 0;
            else if (disp != 0) begin n.fase = 2; n.lote = 0; end
        end else if (m.fase == 2) begin
            if (m.lote == LOTE || m.reg_v == CAP || (disp - int'(m.pulso)) <= 0 || !en)
                n.fase = 3;
            else
                mover = 1;
        end else begin
            n.fase = 0;
        end
        n.pulso = mover;
        if (mover) n.lote = m.lote + 1;
        delta = int'(mover) - int'(cons);
        n.reg_v = m.reg_v + delta;
        if (n.reg_v < 0) n.reg_v = 0;
        if (n.reg_v > CAP) n.reg_v = CAP;
        if (cons && m.reg_v == 0) n.erro = 1;
        return n;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit cons, input bit c);
        enable  = en;
        consumo = cons;
        clr     = c;
    endtask

    task automatic checkOutput();
        cmp("reg_r",          32'(reg1),     32'(m1.reg_v));
        cmp("estado",         32'(estado1),  32'(m1.fase));
        cmp("sec_dec",        32'(sec_dec1), 32'(m1.pulso));
        cmp("ro",             32'(ro1),      32'(m1.reg_v == 0));
        cmp("min_signal",     32'(min1),     32'(m1.reg_v < LIMIAR));
        cmp("em_transf",      32'(em1),      32'(m1.fase == 2));
        cmp("erro_underflow", 32'(err1),     32'(m1.erro));
        cmp("cap_reg_r",      32'(reg2),     32'(m2.reg_v));
        cmp("cap_estado",     32'(estado2),  32'(m2.fase));
        cmp("cap_sec_dec",    32'(sec_dec2), 32'(m2.pulso));
        cmp("cap_min_signal", 32'(min2),     32'(m2.reg_v < CAP));
        cmp("cap_erro",       32'(err2),     32'(m2.erro));
    endtask

    // The secondary buffer follows sec_dec of the main instance with one cycle of latency.
    task automatic stepCycle();
        bit pend;
        int disp;
        pend = (sec_dec1 === 1'b1);
        disp = sec_buf;
        @(posedge clk);
        #1;
        m1 = mstep(m1, LIMIAR, enable, consumo, clr, disp);
        m2 = mstep(m2, CAP, enable, consumo, clr, disp);
        if (pend && sec_buf > 0) sec_buf = sec_buf - 1;
        sec_disp = W'(sec_buf);
        if (sec_dec1 === 1'b1) pulses1++;
        checkOutput();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic loadBuffer(input int v);
        sec_buf  = v;
        sec_disp = W'(v);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pulses1     = 0;
        m1 = '{0, 0, 0, 0, 0};
        m2 = '{0, 0, 0, 0, 0};
        loadBuffer(40);
        applyStimulus(0, 0, 1);
        stepCycle();
        cmp("reset_ro", 32'(ro1), 1);
        cmp("reset_min", 32'(min1), 1);

        $display("[TB] batch refill from full buffer");
        applyStimulus(1, 0, 0);
        stepCycle();
        cmp("t1_espera", 32'(estado1), 1);
        stepCycle();
        cmp("t1_transf", 32'(estado1), 2);
        pulses1 = 0;
        run(20);
        cmp("t1_pulses", 32'(pulses1), 15);
        cmp("t1_reg_r", 32'(reg1), 15);
        cmp("t1_min", 32'(min1), 0);
        cmp("t1_ocioso", 32'(estado1), 0);
        run(10);
        cmp("t1_no_refill", 32'(pulses1), 15);
        cmp("t3_cap_reg_r", 32'(reg2), 20);

        $display("[TB] short buffer with pending-pulse latency");
        applyStimulus(0, 1, 0);
        run(11);
        cmp("t2_start_reg", 32'(reg1), 4);
        applyStimulus(1, 0, 0);
        loadBuffer(3);
        pulses1 = 0;
        run(12);
        cmp("t2_pulses", 32'(pulses1), 3);
        cmp("t2_reg_r", 32'(reg1), 7);
        cmp("t2_buffer", 32'(sec_buf), 0);

        $display("[TB] consumption during transfer");
        applyStimulus(0, 1, 0);
        run(3);
        applyStimulus(1, 0, 0);
        loadBuffer(40);
        run(2);
        cmp("t4_transf", 32'(estado1), 2);
        cmp("t4_reg_before", 32'(reg1), 4);
        pulses1 = 0;
        applyStimulus(1, 1, 0);
        run(5);
        cmp("t4_reg_after", 32'(reg1), 4);
        cmp("t4_pulses", 32'(pulses1), 5);
        applyStimulus(1, 0, 0);
        run(15);
        cmp("t4_reg_end", 32'(reg1), 14);
        cmp("t4_pulses_end", 32'(pulses1), 15);

        $display("[TB] clear during transfer");
        applyStimulus(0, 1, 0);
        run(10);
        applyStimulus(1, 0, 0);
        loadBuffer(40);
        run(2);
        pulses1 = 0;
        run(6);
        cmp("t6_pulses", 32'(pulses1), 6);
        cmp("t6_reg_r", 32'(reg1), 10);
        applyStimulus(1, 0, 1);
        stepCycle();
        cmp("t6_clr_reg", 32'(reg1), 0);
        cmp("t6_clr_estado", 32'(estado1), 0);
        cmp("t6_clr_sec_dec", 32'(sec_dec1), 0);
        applyStimulus(1, 0, 0);
        stepCycle();
        cmp("t6_restart", 32'(estado1), 1);

        $display("[TB] underflow flag");
        applyStimulus(0, 0, 0);
        stepCycle();
        applyStimulus(0, 1, 0);
        stepCycle();
        cmp("t5_reg_r", 32'(reg1), 0);
        cmp("t5_ro", 32'(ro1), 1);
        cmp("t5_erro", 32'(err1), 1);
        applyStimulus(1, 0, 0);
        loadBuffer(40);
        run(25);
        cmp("t5_refilled", 32'(reg1), 15);
        cmp("t5_erro_sticky", 32'(err1), 1);
        applyStimulus(1, 0, 1);
        stepCycle();
        cmp("t5_erro_clr", 32'(err1), 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 8) != 0, ($urandom % 3) == 0, ($urandom % 250) == 0);
            if (sec_buf == 0 && sec_dec1 !== 1'b1 && ($urandom % 4) == 0)
                loadBuffer(int'($urandom_range(0, 45)));
            stepCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
